// File: rtl/resp_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resp_checker_pkg
//  Description : Shared types and constants for the response checker.
//                state_t - run-control states (IDLE, RUN, DONE)
//                ERR_SAT - saturation value of the mismatch counter
//  Revision    : 1.0 - initial release
// ============================================================================
package resp_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

endpackage : resp_checker_pkg
`default_nettype wire

// File: rtl/resp_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : resp_checker_if
//  Description : Bundle of the expected-memory load port, the observed-word
//                stream and the run status of the response checker.
//                master - test controller / unit-under-test side
//                slave  - checker side
//                Optional: RESP_CHECKER_MASK_EN adds exp_mask (per-entry
//                don't-care bits written together with exp_data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface resp_checker_if #(
    parameter int N     = 64,
    parameter int DEPTH = 10,
    parameter int IW    = $clog2(DEPTH)
);
    // expected-memory load
    logic          exp_we;
    logic [IW-1:0] exp_addr;
    logic [N-1:0]  exp_data;
`ifdef RESP_CHECKER_MASK_EN
    logic [N-1:0]  exp_mask;
`endif
    // run control and observed stream
    logic          start;
    logic          obs_valid;
    logic [N-1:0]  obs_data;
    // status
    logic          busy;
    logic          done;
    logic          pass;
    logic [31:0]   vectornum;
    logic [31:0]   errors;
    logic [IW-1:0] first_err_idx;
    logic [N-1:0]  first_err_data;

    modport master (
        output exp_we, exp_addr, exp_data,
`ifdef RESP_CHECKER_MASK_EN
        output exp_mask,
`endif
        output start, obs_valid, obs_data,
        input  busy, done, pass, vectornum, errors, first_err_idx, first_err_data
    );

    modport slave (
        input  exp_we, exp_addr, exp_data,
`ifdef RESP_CHECKER_MASK_EN
        input  exp_mask,
`endif
        input  start, obs_valid, obs_data,
        output busy, done, pass, vectornum, errors, first_err_idx, first_err_data
    );

endinterface : resp_checker_if
`default_nettype wire

// File: rtl/resp_checker_exp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : exp_mem
//  Description : DEPTH x N expected-value register array, synchronous write,
//                combinational read. Contents are deliberately not reset.
//                Optional: RESP_CHECKER_MASK_EN adds a parallel DEPTH x N
//                don't-care mask array written with the same strobe.
//  Ports       : clk               - write clock
//                i_we/i_waddr      - write strobe and index
//                i_wdata (i_wmask) - value (and mask) to store
//                i_raddr           - read index
//                o_rdata (o_rmask) - entry (and mask) at i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_mem #(
    parameter int N     = 64,
    parameter int DEPTH = 10,
    parameter int IW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [IW-1:0] i_waddr,
    input  wire logic [N-1:0]  i_wdata,
`ifdef RESP_CHECKER_MASK_EN
    input  wire logic [N-1:0]  i_wmask,
    output logic      [N-1:0]  o_rmask,
`endif
    input  wire logic [IW-1:0] i_raddr,
    output logic      [N-1:0]  o_rdata
);

    logic [N-1:0] r_data [DEPTH];

    // Index space may exceed DEPTH when DEPTH is not a power of two.
    logic w_wr_ok;
    logic w_rd_ok;
    assign w_wr_ok = (32'(i_waddr) < DEPTH);
    assign w_rd_ok = (32'(i_raddr) < DEPTH);

    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_data[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_data[i_raddr] : '0;

`ifdef RESP_CHECKER_MASK_EN
    logic [N-1:0] r_mask [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mask[i_waddr] <= i_wmask;
        end
    end

    assign o_rmask = w_rd_ok ? r_mask[i_raddr] : '0;
`endif

endmodule : exp_mem
`default_nettype wire

// File: rtl/resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : resp_checker
//  Description : In-order response checker. Holds DEPTH expected words,
//                compares one observed word per obs_valid cycle during a
//                run, counts mismatches (saturating) and latches the index
//                and value of the first mismatch.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - resp_checker_if.slave (load port, observed stream,
//                        busy/done/pass, vectornum, errors, first_err_*)
//  Options     : RESP_CHECKER_MASK_EN - per-entry don't-care mask compare
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_checker
    import resp_checker_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 10,
    parameter int IW    = $clog2(DEPTH)
) (
    input  wire logic      clk,
    input  wire logic      reset,
    resp_checker_if.slave  bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_vectornum;
    logic [31:0]   r_errors;
    logic [IW-1:0] r_first_err_idx;
    logic [N-1:0]  r_first_err_data;

    logic          w_start_run;
    logic          w_consume;
    logic          w_last;
    logic          w_mismatch;
    logic          w_mem_we;
    logic [IW-1:0] w_rd_idx;
    logic [N-1:0]  w_exp;

    // Memory is frozen for the duration of a run.
    assign w_mem_we    = bus.exp_we && (r_state != RUN);
    // start is only honoured outside a run.
    assign w_start_run = bus.start && (r_state != RUN);
    assign w_consume   = (r_state == RUN) && bus.obs_valid;
    assign w_last      = w_consume && (r_vectornum == 32'(DEPTH - 1));
    // vectornum never exceeds DEPTH-1 while in RUN, so the low bits suffice.
    assign w_rd_idx    = r_vectornum[IW-1:0];

`ifdef RESP_CHECKER_MASK_EN
    logic [N-1:0] w_mask;

    exp_mem #(.N(N), .DEPTH(DEPTH), .IW(IW)) u_exp_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.exp_addr),
        .i_wdata (bus.exp_data),
        .i_wmask (bus.exp_mask),
        .o_rmask (w_mask),
        .i_raddr (w_rd_idx),
        .o_rdata (w_exp)
    );

    // Mask bits set to 1 are don't-care.
    assign w_mismatch = |((bus.obs_data ^ w_exp) & ~w_mask);
`else
    exp_mem #(.N(N), .DEPTH(DEPTH), .IW(IW)) u_exp_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.exp_addr),
        .i_wdata (bus.exp_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_exp)
    );

    assign w_mismatch = (bus.obs_data != w_exp);
`endif

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_run) w_state_nxt = RUN;
            RUN:     if (w_last)      w_state_nxt = DONE;
            DONE:    if (w_start_run) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and first-error capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vectornum      <= '0;
            r_errors         <= '0;
            r_first_err_idx  <= '0;
            r_first_err_data <= '0;
        end else if (w_start_run) begin
            r_vectornum      <= '0;
            r_errors         <= '0;
            r_first_err_idx  <= '0;
            r_first_err_data <= '0;
        end else if (w_consume) begin
            r_vectornum <= r_vectornum + 32'd1;
            if (w_mismatch) begin
                if (r_errors != ERR_SAT) begin
                    r_errors <= r_errors + 32'd1;
                end
                // A zero count means no earlier mismatch in this run.
                if (r_errors == '0) begin
                    r_first_err_idx  <= w_rd_idx;
                    r_first_err_data <= bus.obs_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign bus.busy           = (r_state == RUN);
    assign bus.done           = (r_state == DONE);
    assign bus.pass           = (r_state == DONE) && (r_errors == '0);
    assign bus.vectornum      = r_vectornum;
    assign bus.errors         = r_errors;
    assign bus.first_err_idx  = r_first_err_idx;
    assign bus.first_err_data = r_first_err_data;

endmodule : resp_checker
`default_nettype wire
